// File: rtl/seg7_scan_if.sv
// Register-side bundle feeding the 7-segment scan scheduler.
//
// Handshake: load is a single-cycle strobe with no ready/backpressure.
// The slave samples digit_val/dp_mask/en_mask/brightness on every rising
// ACLK edge where load is high, and it always accepts. The master must hold
// the data stable in the cycle in which load is high.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digit_val;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   en_mask;
  logic [3:0]              brightness;
  logic                    load;

  modport master (
    output digit_val, dp_mask, en_mask, brightness, load
  );

  modport slave (
    input digit_val, dp_mask, en_mask, brightness, load
  );
endinterface

// File: rtl/seg7_scan_scheduler.sv
// Time-division scan scheduler for a multiplexed 7-segment display.
// Register values are double-buffered (pending -> active on frame boundary),
// each digit slot starts with a short all-dark guard interval, and lit digits
// are dimmed by a free-running 4-bit PWM. All pin outputs are registered.
module seg7_scan_scheduler #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  seg7_scan_if.slave            regs,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [2:0]            cur_digit,
  output logic                  frame_done
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES);
  localparam logic [2:0]    DIGIT_LAST = 3'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   en_mask;
    logic [3:0]              brightness;
  } frame_t;

  logic [SW-1:0] slot_cnt;
  logic [2:0]    digit_idx;
  logic [3:0]    pwm_cnt;
  frame_t        in_frame;
  frame_t        pending;
  frame_t        active;

  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            nibble;
  logic                  en_bit;
  logic                  dp_bit;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  assign in_frame  = {regs.digit_val, regs.dp_mask, regs.en_mask, regs.brightness};
  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (digit_idx == DIGIT_LAST);

  // Hex to active-low cathodes, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // Slot prescaler, digit index and free-running PWM counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
      pwm_cnt   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (slot_end) begin
        slot_cnt  <= '0;
        digit_idx <= (digit_idx == DIGIT_LAST) ? 3'd0 : digit_idx + 3'd1;
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

  // Double buffer: loads land in pending; active swaps only at frame end,
  // taking a load that coincides with frame end directly from the inputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pending <= '0;
      active  <= '0;
    end else begin
      if (regs.load) pending <= in_frame;
      if (frame_end) active <= regs.load ? in_frame : pending;
    end
  end

  // Select the scanned digit's fields and decide whether it is lit now.
  always_comb begin
    nibble = '0;
    en_bit = 1'b0;
    dp_bit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == 3'(i)) begin
        nibble = active.digits[4*i +: 4];
        en_bit = active.en_mask[i];
        dp_bit = active.dp_mask[i];
      end
    end
    lit      = (slot_cnt >= BLANK_LAST) && en_bit && (pwm_cnt <= active.brightness);
    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (lit) begin
      an_next  = ~(NUM_DIGITS'(1) << digit_idx);
      seg_next = decode(nibble);
      dp_next  = ~dp_bit;
    end
  end

  // Registered pin and status outputs, one cycle behind internal state.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      cur_digit  <= '0;
      frame_done <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      cur_digit  <= digit_idx;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Self-checking bench for seg7_scan_scheduler. dut_a uses an 8-cycle slot
// for frame-level vectors; dut_b uses a 64-cycle slot for PWM duty checks.
module tb_seg7_scan_scheduler;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  seg7_scan_if #(.NUM_DIGITS(N)) ifa ();
  seg7_scan_if #(.NUM_DIGITS(N)) ifb ();

  logic [N-1:0] an_a, an_b;
  logic [6:0]   seg_a, seg_b;
  logic         dp_a, dp_b, fd_a, fd_b;
  logic [2:0]   cd_a, cd_b;

  seg7_scan_scheduler #(.NUM_DIGITS(N), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut_a (
    .ACLK(clk), .ARESETN(rst_n), .regs(ifa.slave),
    .an(an_a), .seg(seg_a), .dp(dp_a), .cur_digit(cd_a), .frame_done(fd_a)
  );

  seg7_scan_scheduler #(.NUM_DIGITS(N), .REFRESH_DIV(64), .BLANK_CYCLES(2)) dut_b (
    .ACLK(clk), .ARESETN(rst_n), .regs(ifb.slave),
    .an(an_b), .seg(seg_b), .dp(dp_b), .cur_digit(cd_b), .frame_done(fd_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] dv;
    logic [7:0]  dpm;
    logic [7:0]  enm;
    logic [3:0]  br;
    int          load_at;
    int          decoy_at;
  } vec_t;

  vec_t vecs[6];
  vec_t none_v;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  // Spec decode table, {g,f,e,d,c,b,a} active-low.
  function automatic logic [6:0] spec_decode(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Expected {cur_digit, an, seg, dp, frame_done} at cycle c of a dut_a frame.
  // Frame is 64 cycles (multiple of 16), so pwm_cnt == c % 16 in every frame.
  function automatic logic [19:0] frame_exp(input logic [31:0] dv, input logic [7:0] dpm,
                                            input logic [7:0] enm, input logic [3:0] br,
                                            input int c);
    int d, j, pwm;
    logic lit;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    d = c / 8;
    j = c % 8;
    pwm = c % 16;
    lit = (j >= 2) && enm[d] && (pwm <= int'(br));
    e_an = 8'hFF;
    e_seg = 7'h7F;
    e_dp = 1'b1;
    if (lit) begin
      e_an = ~(8'h01 << d);
      e_seg = spec_decode(dv[4*d +: 4]);
      e_dp = ~dpm[d];
    end
    return {3'(d), e_an, e_seg, e_dp, (c == 63)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_regs(input logic [31:0] dv, input logic [7:0] dpm, input logic [7:0] enm,
                            input logic [3:0] br, input logic ld);
    ifa.digit_val = dv;  ifa.dp_mask = dpm;  ifa.en_mask = enm;
    ifa.brightness = br; ifa.load = ld;
    ifb.digit_val = dv;  ifb.dp_mask = dpm;  ifb.en_mask = enm;
    ifb.brightness = br; ifb.load = ld;
  endtask

  task automatic clear_load();
    ifa.load = 1'b0;
    ifb.load = 1'b0;
  endtask

  task automatic wait_fd_a(input int bound, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd_a && n < bound);
    check({name, "_timeout"}, n, 32'(fd_a), 32'd1);
  endtask

  task automatic wait_fd_b(input int bound, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd_b && n < bound);
    check({name, "_timeout"}, n, 32'(fd_b), 32'd1);
  endtask

  // Must be entered at the negedge where fd_a is seen high. Checks the whole
  // next frame against (dv,dpm,enm,br) and optionally issues loads of nv.
  task automatic check_frame(input string name, input logic [31:0] dv, input logic [7:0] dpm,
                             input logic [7:0] enm, input logic [3:0] br, input vec_t nv);
    logic [19:0] e;
    for (int c = 0; c < 64; c++) exp_q.push_back(frame_exp(dv, dpm, enm, br, c));
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      clear_load();
      e = exp_q.pop_front();
      check(name, c, {12'd0, cd_a, an_a, seg_a, dp_a, fd_a}, {12'd0, e});
      if (c == nv.decoy_at) drive_regs(~nv.dv, 8'h00, 8'hFF, 4'd15, 1'b1);
      if (c == nv.load_at) drive_regs(nv.dv, nv.dpm, nv.enm, nv.br, 1'b1);
    end
  endtask

  // After reset release: dark every cycle until the first frame_done, which
  // must arrive exactly 64 cycles after release.
  task automatic dark_until_frame(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check({name, "_dark"}, n, {16'd0, an_a, seg_a, dp_a}, {16'd0, 8'hFF, 7'h7F, 1'b1});
    end while (!fd_a && n < 100);
    check({name, "_first_frame_len"}, 0, 32'(n), 32'd64);
  endtask

  // dut_b: digit 0 slot of a frame with brightness br, digit value 8.
  task automatic check_pwm_slot(input string name, input int br);
    logic lit;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      lit = (j >= 2) && ((j % 16) <= br);
      check(name, j, {17'd0, an_b, seg_b},
            lit ? {17'd0, 8'hFE, 7'b0000000} : {17'd0, 8'hFF, 7'h7F});
    end
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] cur_dv;
  logic [7:0]  cur_dpm, cur_enm;
  logic [3:0]  cur_br;

  initial begin
    none_v = '{"none", 32'h0, 8'h0, 8'h0, 4'h0, -1, -1};
    vecs[0] = '{"basic",      32'h76543210, 8'h01, 8'hFF, 4'd15,  5, -1};
    vecs[1] = '{"slot3_load", 32'hFFFFFFFF, 8'h00, 8'hFF, 4'd15, 30, -1};
    vecs[2] = '{"fend_load",  32'hFEDCBA98, 8'hAA, 8'hFF, 4'd15, 62, -1};
    vecs[3] = '{"en_a5",      32'h76543210, 8'hFF, 8'hA5, 4'd15, 20, -1};
    vecs[4] = '{"dim7",       32'h13579BDF, 8'h0F, 8'hFF, 4'd7,  40, -1};
    vecs[5] = '{"last_wins",  32'h24682468, 8'h81, 8'h3C, 4'd15, 50, 10};

    // Reset held for 20 cycles.
    drive_regs(32'h0, 8'h0, 8'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_an", 0, 32'(an_a), 32'hFF);
    check("rst_seg", 0, 32'(seg_a), 32'h7F);
    check("rst_dp", 0, 32'(dp_a), 32'd1);
    check("rst_cur_digit", 0, 32'(cd_a), 32'd0);
    check("rst_frame_done", 0, 32'(fd_a), 32'd0);
    rst_n = 1'b1;
    dark_until_frame("reset");

    // Nothing loaded yet: the next frame stays dark; first vector loads in it.
    cur_dv = 32'h0; cur_dpm = 8'h0; cur_enm = 8'h0; cur_br = 4'h0;
    for (int i = 0; i < 6; i++) begin
      check_frame({vecs[i].name, "_before"}, cur_dv, cur_dpm, cur_enm, cur_br, vecs[i]);
      cur_dv = vecs[i].dv; cur_dpm = vecs[i].dpm; cur_enm = vecs[i].enm; cur_br = vecs[i].br;
    end
    check_frame("last_wins_after", cur_dv, cur_dpm, cur_enm, cur_br, none_v);

    // PWM duty on dut_b (64-cycle slots): brightness 3, then 0.
    @(negedge clk);
    drive_regs(32'h8, 8'h00, 8'h01, 4'd3, 1'b1);
    @(negedge clk);
    clear_load();
    wait_fd_b(1200, "pwm3");
    check_pwm_slot("pwm3", 3);
    drive_regs(32'h8, 8'h00, 8'h01, 4'd0, 1'b1);
    @(negedge clk);
    clear_load();
    wait_fd_b(1200, "pwm0");
    check_pwm_slot("pwm0", 0);

    // Asynchronous reset in slot 5 of a lit frame.
    drive_regs(32'h76543210, 8'h20, 8'hFF, 4'd15, 1'b1);
    @(negedge clk);
    clear_load();
    wait_fd_a(100, "areset_sync");
    repeat (43) @(negedge clk);
    check("pre_reset_an", 0, 32'(an_a), 32'hDF);
    check("pre_reset_dp", 0, 32'(dp_a), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_an", 0, 32'(an_a), 32'hFF);
    check("areset_seg", 0, 32'(seg_a), 32'h7F);
    check("areset_dp", 0, 32'(dp_a), 32'd1);
    check("areset_cur_digit", 0, 32'(cd_a), 32'd0);
    check("areset_an_b", 0, 32'(an_b), 32'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_cur_digit", 0, 32'(cd_a), 32'd0);
    check("post_reset_an", 0, 32'(an_a), 32'hFF);
    // One cycle already consumed; remaining 63 to the first frame_done.
    begin
      int n;
      n = 1;
      while (!fd_a && n < 100) begin
        @(negedge clk);
        n++;
        check("post_reset_dark", n, {16'd0, an_a, seg_a, dp_a}, {16'd0, 8'hFF, 7'h7F, 1'b1});
      end
      check("post_reset_frame_len", 0, 32'(n), 32'd64);
    end
    check_frame("post_reset_frame", 32'h0, 8'h0, 8'h0, 4'h0, none_v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
